// File: rtl/mem_arb_2to1_pkg.sv
// Shared constants and types for the two-requester data-memory arbiter.
package mem_arb_2to1_pkg;

  localparam int unsigned AddrW = 30;
  localparam int unsigned DataW = 32;
  localparam int unsigned MaskW = 4;

  typedef logic arb_id_t;

  localparam arb_id_t ARB_ID_M0 = 1'b0;
  localparam arb_id_t ARB_ID_M1 = 1'b1;

  typedef struct packed {
    logic    v;
    arb_id_t id;
  } rsp_ent_t;

endpackage

// File: rtl/mem_arb_2to1_if.sv
// Requester-side bus: request handshake plus the returning read-data channel.
interface mem_arb_2to1_if;
  import mem_arb_2to1_pkg::*;

  logic             valid;
  logic             ready;
  logic [AddrW-1:0] addr;
  logic [DataW-1:0] wdata;
  logic             we;
  logic [MaskW-1:0] mask;
  logic             lock;
  logic             rvalid;
  logic [DataW-1:0] rdata;

  modport master (
    output valid, addr, wdata, we, mask, lock,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wdata, we, mask, lock,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/mem_arb_2to1_rsp_pipe.sv
// Fixed-depth shift register tracking which port owns each in-flight read.
module mem_arb_2to1_rsp_pipe
  import mem_arb_2to1_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  rsp_ent_t push_i,
  output rsp_ent_t tail_o
);

  rsp_ent_t [Depth-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = push_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tail_o = pipe_q[Depth-1];

endmodule

// File: rtl/mem_arb_2to1.sv
// Two-port round-robin arbiter in front of a single-port fixed-latency memory,
// with bounded burst locking and per-port read response routing.
module mem_arb_2to1
  import mem_arb_2to1_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_arb_2to1_if.slave    m0,
  mem_arb_2to1_if.slave    m1,
  output logic             o_mem_valid,
  output logic [AddrW-1:0] o_mem_addr,
  output logic [DataW-1:0] o_mem_data,
  output logic             o_mem_we,
  output logic [MaskW-1:0] o_mem_mask,
  input  logic [DataW-1:0] i_mem_data
);

  localparam int unsigned     CntW     = $clog2(LOCK_MAX + 1);
  localparam logic [CntW-1:0] LockMaxC = CntW'(LOCK_MAX);

  arb_id_t         rr_q, rr_d;
  logic            lock_q, lock_d;
  arb_id_t         owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

  logic [1:0]       req;
  logic             gnt_vld;
  arb_id_t          gnt_id;
  logic [AddrW-1:0] g_addr;
  logic [DataW-1:0] g_wdata;
  logic             g_we;
  logic [MaskW-1:0] g_mask;
  logic             g_lock;

  rsp_ent_t rsp_push, rsp_tail;

  assign req = {m1.valid, m0.valid};

  // While locked the non-owner is starved even if the owner has nothing to send.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ARB_ID_M0;
    if (!rst) begin
      if (lock_q) begin
        gnt_vld = req[owner_q];
        gnt_id  = owner_q;
      end else if (req[0] && req[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_q;
      end else if (req[0]) begin
        gnt_vld = 1'b1;
        gnt_id  = ARB_ID_M0;
      end else if (req[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = ARB_ID_M1;
      end
    end
  end

  always_comb begin
    g_addr  = m0.addr;
    g_wdata = m0.wdata;
    g_we    = m0.we;
    g_mask  = m0.mask;
    g_lock  = m0.lock;
    if (gnt_id == ARB_ID_M1) begin
      g_addr  = m1.addr;
      g_wdata = m1.wdata;
      g_we    = m1.we;
      g_mask  = m1.mask;
      g_lock  = m1.lock;
    end
  end

  assign m0.ready    = gnt_vld & (gnt_id == ARB_ID_M0);
  assign m1.ready    = gnt_vld & (gnt_id == ARB_ID_M1);
  assign o_mem_valid = gnt_vld;
  assign o_mem_addr  = gnt_vld ? g_addr  : '0;
  assign o_mem_data  = gnt_vld ? g_wdata : '0;
  assign o_mem_we    = gnt_vld & g_we;
  assign o_mem_mask  = gnt_vld ? g_mask  : '0;

  // The acquiring beat counts as the first locked beat; reaching LOCK_MAX forces release.
  always_comb begin
    rr_d    = rr_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    cnt_inc = lock_q ? cnt_q + CntW'(1) : CntW'(1);
    if (gnt_vld) begin
      if (g_lock && (cnt_inc < LockMaxC)) begin
        lock_d  = 1'b1;
        owner_d = gnt_id;
        cnt_d   = cnt_inc;
      end else begin
        lock_d = 1'b0;
        cnt_d  = '0;
        rr_d   = ~gnt_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= ARB_ID_M0;
      lock_q  <= 1'b0;
      owner_q <= ARB_ID_M0;
      cnt_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_push.v  = gnt_vld & ~g_we;
  assign rsp_push.id = gnt_id;

  mem_arb_2to1_rsp_pipe #(
    .Depth (RD_LAT)
  ) u_rsp_pipe (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (rsp_push),
    .tail_o (rsp_tail)
  );

  assign m0.rvalid = ~rst & rsp_tail.v & (rsp_tail.id == ARB_ID_M0);
  assign m1.rvalid = ~rst & rsp_tail.v & (rsp_tail.id == ARB_ID_M1);
  assign m0.rdata  = m0.rvalid ? i_mem_data : '0;
  assign m1.rdata  = m1.rvalid ? i_mem_data : '0;

endmodule

// File: tb/tb_mem_arb_2to1.sv
// Two arbiter configurations driven in lockstep and checked against a behavioural model.
module tb_mem_arb_2to1;
  import mem_arb_2to1_pkg::*;

  localparam int unsigned LatA  = 1;
  localparam int unsigned LmaxA = 16;
  localparam int unsigned LatB  = 3;
  localparam int unsigned LmaxB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       v, we, lk;
  logic [AddrW-1:0] addr [2];
  logic [DataW-1:0] wd   [2];
  logic [MaskW-1:0] mk   [2];
  logic [DataW-1:0] mem_rd;
  bit               keep;

  mem_arb_2to1_if a_m0 ();
  mem_arb_2to1_if a_m1 ();
  mem_arb_2to1_if b_m0 ();
  mem_arb_2to1_if b_m1 ();

  assign a_m0.valid = v[0];   assign b_m0.valid = v[0];
  assign a_m0.addr  = addr[0]; assign b_m0.addr  = addr[0];
  assign a_m0.wdata = wd[0];  assign b_m0.wdata = wd[0];
  assign a_m0.we    = we[0];  assign b_m0.we    = we[0];
  assign a_m0.mask  = mk[0];  assign b_m0.mask  = mk[0];
  assign a_m0.lock  = lk[0];  assign b_m0.lock  = lk[0];
  assign a_m1.valid = v[1];   assign b_m1.valid = v[1];
  assign a_m1.addr  = addr[1]; assign b_m1.addr  = addr[1];
  assign a_m1.wdata = wd[1];  assign b_m1.wdata = wd[1];
  assign a_m1.we    = we[1];  assign b_m1.we    = we[1];
  assign a_m1.mask  = mk[1];  assign b_m1.mask  = mk[1];
  assign a_m1.lock  = lk[1];  assign b_m1.lock  = lk[1];

  logic             mv_a, mv_b, mwe_a, mwe_b;
  logic [AddrW-1:0] maddr_a, maddr_b;
  logic [DataW-1:0] mdata_a, mdata_b;
  logic [MaskW-1:0] mmask_a, mmask_b;

  mem_arb_2to1 #(.RD_LAT(LatA), .LOCK_MAX(LmaxA)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .m0          (a_m0),
    .m1          (a_m1),
    .o_mem_valid (mv_a),
    .o_mem_addr  (maddr_a),
    .o_mem_data  (mdata_a),
    .o_mem_we    (mwe_a),
    .o_mem_mask  (mmask_a),
    .i_mem_data  (mem_rd)
  );

  mem_arb_2to1 #(.RD_LAT(LatB), .LOCK_MAX(LmaxB)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .m0          (b_m0),
    .m1          (b_m1),
    .o_mem_valid (mv_b),
    .o_mem_addr  (maddr_b),
    .o_mem_data  (mdata_b),
    .o_mem_we    (mwe_b),
    .o_mem_mask  (mmask_b),
    .i_mem_data  (mem_rd)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: preferred port, lock owner and run length, and a calendar of due read responses.
  int lat  [2];
  int lmax [2];
  int pref [2];
  int lckd [2];
  int ownr [2];
  int runl [2];
  int gnt  [2];
  int sched [2][8];

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    for (int k = 0; k < 2; k++) begin
      int g;
      int e;
      logic [31:0] o_r0, o_r1, o_mv, o_ma, o_md, o_mw, o_mm, o_v0, o_v1, o_d0, o_d1;
      g = -1;
      if (!rst) begin
        if (lckd[k] != 0) begin
          if (v[ownr[k]]) g = ownr[k];
        end else if (v[0] && v[1]) begin
          g = pref[k];
        end else if (v[0]) begin
          g = 0;
        end else if (v[1]) begin
          g = 1;
        end
      end
      gnt[k] = g;
      e = rst ? -1 : sched[k][cyc % 8];
      if (k == 0) begin
        o_r0 = 32'(a_m0.ready);  o_r1 = 32'(a_m1.ready);
        o_v0 = 32'(a_m0.rvalid); o_v1 = 32'(a_m1.rvalid);
        o_d0 = a_m0.rdata;       o_d1 = a_m1.rdata;
        o_mv = 32'(mv_a); o_ma = 32'(maddr_a); o_md = mdata_a;
        o_mw = 32'(mwe_a); o_mm = 32'(mmask_a);
      end else begin
        o_r0 = 32'(b_m0.ready);  o_r1 = 32'(b_m1.ready);
        o_v0 = 32'(b_m0.rvalid); o_v1 = 32'(b_m1.rvalid);
        o_d0 = b_m0.rdata;       o_d1 = b_m1.rdata;
        o_mv = 32'(mv_b); o_ma = 32'(maddr_b); o_md = mdata_b;
        o_mw = 32'(mwe_b); o_mm = 32'(mmask_b);
      end
      chk("m0_ready", k, o_r0, 32'(g == 0));
      chk("m1_ready", k, o_r1, 32'(g == 1));
      chk("mem_valid", k, o_mv, 32'(g >= 0));
      chk("mem_addr", k, o_ma, (g >= 0) ? 32'(addr[g]) : 32'd0);
      chk("mem_data", k, o_md, (g >= 0) ? wd[g] : 32'd0);
      chk("mem_we", k, o_mw, (g >= 0) ? 32'(we[g]) : 32'd0);
      chk("mem_mask", k, o_mm, (g >= 0) ? 32'(mk[g]) : 32'd0);
      chk("m0_rvalid", k, o_v0, 32'(e == 0));
      chk("m1_rvalid", k, o_v1, 32'(e == 1));
      chk("m0_rdata", k, o_d0, (e == 0) ? mem_rd : 32'd0);
      chk("m1_rdata", k, o_d1, (e == 1) ? mem_rd : 32'd0);
    end
  endtask

  task automatic update_model();
    for (int k = 0; k < 2; k++) begin
      int g;
      int n;
      g = gnt[k];
      if (rst) begin
        pref[k] = 0; lckd[k] = 0; ownr[k] = 0; runl[k] = 0;
        for (int i = 0; i < 8; i++) sched[k][i] = -1;
      end else begin
        sched[k][cyc % 8] = -1;
        if (g >= 0) begin
          if (!we[g]) sched[k][(cyc + lat[k]) % 8] = g;
          n = (lckd[k] != 0) ? runl[k] + 1 : 1;
          if (lk[g] && n < lmax[k]) begin
            lckd[k] = 1; ownr[k] = g; runl[k] = n;
          end else begin
            lckd[k] = 0; runl[k] = 0; pref[k] = 1 - g;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic step(input logic r, input logic [1:0] vv, input logic [1:0] ww,
                      input logic [1:0] ll);
    rst = r; v = vv; we = ww; lk = ll;
    if (!keep) begin
      for (int i = 0; i < 2; i++) begin
        addr[i] = AddrW'($urandom);
        wd[i]   = $urandom;
        mk[i]   = MaskW'($urandom);
      end
    end
    mem_rd = $urandom;
    #4;
    check_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  initial begin
    lat[0] = LatA;  lat[1] = LatB;
    lmax[0] = LmaxA; lmax[1] = LmaxB;
    for (int k = 0; k < 2; k++) begin
      pref[k] = 0; lckd[k] = 0; ownr[k] = 0; runl[k] = 0; gnt[k] = -1;
      for (int i = 0; i < 8; i++) sched[k][i] = -1;
    end
    keep = 1'b0;
    rst = 1'b1; v = '0; we = '0; lk = '0; mem_rd = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wd[i] = '0; mk[i] = '0;
    end
    @(posedge clk);
    #1;

    // Reset
    step(1'b1, 2'b00, 2'b00, 2'b00);
    step(1'b1, 2'b11, 2'b00, 2'b00);

    // Lone m0 read at 0x10
    keep = 1'b1;
    addr[0] = 30'h10;
    step(1'b0, 2'b01, 2'b00, 2'b00);
    keep = 1'b0;
    repeat (4) step(1'b0, 2'b00, 2'b00, 2'b00);

    // Both ports reading continuously
    repeat (4) step(1'b0, 2'b11, 2'b00, 2'b00);
    repeat (4) step(1'b0, 2'b00, 2'b00, 2'b00);

    // m1 write with partial mask
    keep = 1'b1;
    addr[1] = 30'h20; wd[1] = 32'hDEADBEEF; mk[1] = 4'hC;
    step(1'b0, 2'b10, 2'b10, 2'b00);
    keep = 1'b0;
    repeat (4) step(1'b0, 2'b00, 2'b00, 2'b00);

    // m1 three locked beats then an unlocked one, m0 always waiting
    step(1'b0, 2'b10, 2'b00, 2'b10);
    repeat (2) step(1'b0, 2'b11, 2'b00, 2'b10);
    step(1'b0, 2'b11, 2'b00, 2'b00);
    repeat (2) step(1'b0, 2'b01, 2'b00, 2'b00);
    repeat (4) step(1'b0, 2'b00, 2'b00, 2'b00);

    // Lock held forever by m1: forced release in the LOCK_MAX=4 instance
    repeat (12) step(1'b0, 2'b11, 2'b00, 2'b10);
    // Owner idle while locked: m0 must still wait
    repeat (2) step(1'b0, 2'b01, 2'b00, 2'b10);
    step(1'b0, 2'b10, 2'b00, 2'b00);
    repeat (4) step(1'b0, 2'b00, 2'b00, 2'b00);

    // Reset with reads in flight, then a simultaneous request
    repeat (3) step(1'b0, 2'b01, 2'b00, 2'b00);
    step(1'b1, 2'b00, 2'b00, 2'b00);
    step(1'b0, 2'b11, 2'b00, 2'b00);
    repeat (4) step(1'b0, 2'b00, 2'b00, 2'b00);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic [1:0] ll;
      r     = ($urandom_range(0, 59) == 0);
      ll[0] = ($urandom_range(0, 2) == 0);
      ll[1] = ($urandom_range(0, 1) == 0);
      step(r, 2'($urandom), 2'($urandom), ll);
    end
    repeat (4) step(1'b0, 2'b00, 2'b00, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
